// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: fetch PC owner and {pc, instr, fault} queue between imem and decode.
// Define IF_MISALIGN_TRAP_EN to turn misaligned redirect targets into a single fault entry.
`ifndef XLEN_32b
`define XLEN_32b 2'd1
`endif
`ifndef XLEN_64b
`define XLEN_64b 2'd2
`endif
module if_prefetch_queue #(
  parameter logic [1:0] XLEN = `XLEN_64b,
  localparam int AW = 1 << (XLEN + 4),
  parameter int DEPTH = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  output logic [AW-1:0] o_imem_adr,
  input  logic [31:0]   i_imem_instr,
  input  logic          i_stall,
  input  logic          i_redirect,
  input  logic [AW-1:0] i_redirect_pc,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [AW-1:0] o_pc,
  output logic [31:0]   o_instr,
  output logic          o_fault
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic [AW-1:0] r_fpc;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [AW-1:0] q_pc [DEPTH];
  logic [31:0]   q_instr [DEPTH];
  logic          pop;
  logic          push;
  logic          push_fault;
  logic          fetch_en;
  logic          pend_fault;
  logic [AW-1:0] redirect_pc;
`ifdef IF_MISALIGN_TRAP_EN
  logic q_fault [DEPTH];
  logic misaligned;
  assign redirect_pc = i_redirect_pc;
  assign misaligned = |i_redirect_pc[1:0];
  // a misaligned target parks fetch until the next redirect, after queuing one fault entry
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fetch_en <= 1'b1;
      pend_fault <= 1'b0;
    end else if (i_redirect) begin
      fetch_en <= !misaligned;
      pend_fault <= misaligned;
    end else if (push_fault) begin
      pend_fault <= 1'b0;
    end
  end
  always_ff @(posedge i_clk)
    if (push) q_fault[wr_ptr] <= push_fault;
  assign o_fault = o_valid & q_fault[rd_ptr];
`else
  assign redirect_pc = i_redirect_pc & ~AW'(3);
  assign fetch_en = 1'b1;
  assign pend_fault = 1'b0;
  assign o_fault = 1'b0;
`endif
  assign o_imem_adr = r_fpc;
  assign o_valid = count != '0;
  assign pop = o_valid & i_ready;
  assign push = !i_stall & !i_redirect & (fetch_en | pend_fault) & ((count != FULL) | pop);
  assign push_fault = push & pend_fault;
  assign o_pc = o_valid ? q_pc[rd_ptr] : '0;
  assign o_instr = o_valid ? q_instr[rd_ptr] : NOP;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fpc <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (i_redirect) begin
      r_fpc <= redirect_pc;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push && !push_fault) r_fpc <= r_fpc + AW'(4);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW + 1)'(push) - (PW + 1)'(pop);
    end
  end
  always_ff @(posedge i_clk) begin
    if (push) begin
      q_pc[wr_ptr] <= r_fpc;
      q_instr[wr_ptr] <= push_fault ? NOP : i_imem_instr;
    end
  end
endmodule
